// File: rtl/rom_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// rom_port_arbiter_if
//   Requester, response and genrom-side signals of the shared ROM read port.
//   Revision: 1.0
// ============================================================================
interface rom_port_arbiter_if #(
  parameter int MEM_ADDR  = 4,
  parameter int MEM_EXTRA = 4
);
  localparam int DW = (2 ** MEM_EXTRA) * 8;

  logic                 req0_valid;
  logic [MEM_ADDR:0]    req0_addr;
  logic [MEM_EXTRA-1:0] req0_extra;
  logic                 req0_ready;
  logic                 req0_flush;

  logic                 req1_valid;
  logic [MEM_ADDR:0]    req1_addr;
  logic [MEM_EXTRA-1:0] req1_extra;
  logic                 req1_ready;
  logic [MEM_ADDR:0]    req1_lower;
  logic [MEM_ADDR:0]    req1_upper;

  logic                 resp0_valid;
  logic                 resp1_valid;
  logic [DW-1:0]        resp_data;
  logic                 resp_error;

  logic [MEM_ADDR:0]    mem_addr;
  logic [MEM_EXTRA-1:0] mem_extra;
  logic [MEM_ADDR:0]    mem_lower;
  logic [MEM_ADDR:0]    mem_upper;
  logic [DW-1:0]        mem_data;
  logic                 mem_error;

  // Environment side: both requesters plus the genrom read port.
  modport master (
    output req0_valid, req0_addr, req0_extra, req0_flush,
    output req1_valid, req1_addr, req1_extra, req1_lower, req1_upper,
    output mem_data, mem_error,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid,
    input  resp_data, resp_error,
    input  mem_addr, mem_extra, mem_lower, mem_upper
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_addr, req0_extra, req0_flush,
    input  req1_valid, req1_addr, req1_extra, req1_lower, req1_upper,
    input  mem_data, mem_error,
    output req0_ready, req1_ready, resp0_valid, resp1_valid,
    output resp_data, resp_error,
    output mem_addr, mem_extra, mem_lower, mem_upper
  );
endinterface : rom_port_arbiter_if
`default_nettype wire

// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// rom_port_arbiter
//   Two-requester arbiter for the genrom read port with in-order tag tracking.
//   Revision: 1.0
// ============================================================================
module rom_port_arbiter #(
  parameter int MEM_ADDR   = 4,
  parameter int MEM_EXTRA  = 4,
  parameter int LAT        = 2,
  parameter int FIXED_PRIO = 0
) (
  input  wire logic         clk,
  input  wire logic         reset,
  rom_port_arbiter_if.slave bus
);

  localparam logic [MEM_ADDR:0] c_ADDR_ONES = '1;

  logic                 w_grant0;
  logic                 w_grant1;
  logic                 r_last_grant;

  logic [LAT-1:0]       r_tag_vld;
  logic [LAT-1:0]       r_tag_id;
  logic [LAT-1:0]       w_tag_vld_nxt;
  logic [LAT-1:0]       w_tag_id_nxt;

  logic [MEM_ADDR:0]    r_mem_addr;
  logic [MEM_EXTRA-1:0] r_mem_extra;
  logic [MEM_ADDR:0]    r_mem_lower;
  logic [MEM_ADDR:0]    r_mem_upper;

  // Gating with reset keeps ready low for the whole time reset is asserted.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (reset) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if ((FIXED_PRIO != 0) || r_last_grant) begin
          w_grant0 = 1'b1;
        end else begin
          w_grant1 = 1'b1;
        end
      end else begin
        w_grant0 = bus.req0_valid;
        w_grant1 = bus.req1_valid;
      end
    end
  end

  // Flush kills requester-0 entries as they shift; the new load is unaffected.
  always_comb begin
    w_tag_vld_nxt = '0;
    w_tag_id_nxt  = '0;
    for (int i = LAT - 1; i > 0; i--) begin
      w_tag_vld_nxt[i] = r_tag_vld[i-1] & ~(bus.req0_flush & ~r_tag_id[i-1]);
      w_tag_id_nxt[i]  = r_tag_id[i-1];
    end
    w_tag_vld_nxt[0] = w_grant0 | w_grant1;
    w_tag_id_nxt[0]  = w_grant1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld <= w_tag_vld_nxt;
      r_tag_id  <= w_tag_id_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= 1'b1;
      r_mem_addr   <= '0;
      r_mem_extra  <= '0;
      r_mem_lower  <= '0;
      r_mem_upper  <= c_ADDR_ONES;
    end else if (w_grant1) begin
      r_last_grant <= 1'b1;
      r_mem_addr   <= bus.req1_addr;
      r_mem_extra  <= bus.req1_extra;
      r_mem_lower  <= bus.req1_lower;
      r_mem_upper  <= bus.req1_upper;
    end else if (w_grant0) begin
      r_last_grant <= 1'b0;
      r_mem_addr   <= bus.req0_addr;
      r_mem_extra  <= bus.req0_extra;
      r_mem_lower  <= '0;
      r_mem_upper  <= c_ADDR_ONES;
    end
  end

  assign bus.req0_ready  = w_grant0;
  assign bus.req1_ready  = w_grant1;
  assign bus.resp0_valid = r_tag_vld[LAT-1] & ~r_tag_id[LAT-1];
  assign bus.resp1_valid = r_tag_vld[LAT-1] &  r_tag_id[LAT-1];
  assign bus.resp_data   = bus.mem_data;
  assign bus.resp_error  = bus.mem_error;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_extra   = r_mem_extra;
  assign bus.mem_lower   = r_mem_lower;
  assign bus.mem_upper   = r_mem_upper;

endmodule : rom_port_arbiter
`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rom_port_arbiter
//   Round-robin and fixed-priority instances against a time-scheduled model.
//   Revision: 1.0
// ============================================================================
module tb_rom_port_arbiter;
  localparam int MEM_ADDR  = 4;
  localparam int MEM_EXTRA = 4;
  localparam int LAT       = 2;
  localparam int DW        = (2 ** MEM_EXTRA) * 8;
  localparam int CW        = DW + 1;
  localparam int NS        = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic                 d_req0_valid = 1'b0;
  logic [MEM_ADDR:0]    d_req0_addr  = '0;
  logic [MEM_EXTRA-1:0] d_req0_extra = '0;
  logic                 d_req0_flush = 1'b0;
  logic                 d_req1_valid = 1'b0;
  logic [MEM_ADDR:0]    d_req1_addr  = '0;
  logic [MEM_EXTRA-1:0] d_req1_extra = '0;
  logic [MEM_ADDR:0]    d_req1_lower = '0;
  logic [MEM_ADDR:0]    d_req1_upper = '1;

  rom_port_arbiter_if #(.MEM_ADDR(MEM_ADDR), .MEM_EXTRA(MEM_EXTRA)) bus0 ();
  rom_port_arbiter_if #(.MEM_ADDR(MEM_ADDR), .MEM_EXTRA(MEM_EXTRA)) bus1 ();

  logic [DW:0] rom_q0 = '0;
  logic [DW:0] rom_q1 = '0;

  assign bus0.req0_valid = d_req0_valid;  assign bus1.req0_valid = d_req0_valid;
  assign bus0.req0_addr  = d_req0_addr;   assign bus1.req0_addr  = d_req0_addr;
  assign bus0.req0_extra = d_req0_extra;  assign bus1.req0_extra = d_req0_extra;
  assign bus0.req0_flush = d_req0_flush;  assign bus1.req0_flush = d_req0_flush;
  assign bus0.req1_valid = d_req1_valid;  assign bus1.req1_valid = d_req1_valid;
  assign bus0.req1_addr  = d_req1_addr;   assign bus1.req1_addr  = d_req1_addr;
  assign bus0.req1_extra = d_req1_extra;  assign bus1.req1_extra = d_req1_extra;
  assign bus0.req1_lower = d_req1_lower;  assign bus1.req1_lower = d_req1_lower;
  assign bus0.req1_upper = d_req1_upper;  assign bus1.req1_upper = d_req1_upper;
  assign bus0.mem_data   = rom_q0[DW-1:0]; assign bus0.mem_error = rom_q0[DW];
  assign bus1.mem_data   = rom_q1[DW-1:0]; assign bus1.mem_error = rom_q1[DW];

  rom_port_arbiter #(.MEM_ADDR(MEM_ADDR), .MEM_EXTRA(MEM_EXTRA), .LAT(LAT), .FIXED_PRIO(0))
    u_dut_rr (.clk(clk), .reset(reset), .bus(bus0));
  rom_port_arbiter #(.MEM_ADDR(MEM_ADDR), .MEM_EXTRA(MEM_EXTRA), .LAT(LAT), .FIXED_PRIO(1))
    u_dut_fp (.clk(clk), .reset(reset), .bus(bus1));

  // genrom stand-in: byte i holds i, error when the window leaves [lower, upper].
  function automatic logic [DW:0] rom_read(input logic [MEM_ADDR:0] addr,
                                            input logic [MEM_EXTRA-1:0] extra,
                                            input logic [MEM_ADDR:0] lo,
                                            input logic [MEM_ADDR:0] up);
    logic [DW-1:0] d;
    logic          e;
    int            a;
    d = '0;
    a = int'(addr);
    for (int k = 0; k <= int'(extra); k++)
      if (a + k < 32) d[k*8 +: 8] = 8'(a + k);
    e = (a < int'(lo)) || (a + int'(extra) > int'(up));
    return {e, d};
  endfunction

  always @(posedge clk) begin
    rom_q0 <= rom_read(bus0.mem_addr, bus0.mem_extra, bus0.mem_lower, bus0.mem_upper);
    rom_q1 <= rom_read(bus1.mem_addr, bus1.mem_extra, bus1.mem_lower, bus1.mem_upper);
  end

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  task automatic check_eq(input string tag, input logic [DW:0] act, input logic [DW:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Model: expected responses are booked into the cycle they are due.
  bit                   s_vld  [2][NS];
  bit                   s_id   [2][NS];
  logic [MEM_ADDR:0]    s_addr [2][NS];
  logic [MEM_EXTRA-1:0] s_ext  [2][NS];
  logic [MEM_ADDR:0]    s_lo   [2][NS];
  logic [MEM_ADDR:0]    s_up   [2][NS];
  bit                   m_last [2];
  logic [MEM_ADDR:0]    m_addr [2];
  logic [MEM_EXTRA-1:0] m_ext  [2];
  logic [MEM_ADDR:0]    m_lo   [2];
  logic [MEM_ADDR:0]    m_up   [2];

  task automatic model_reset(input int i);
    for (int k = 0; k < NS; k++) s_vld[i][k] = 1'b0;
    m_last[i] = 1'b1;
    m_addr[i] = '0;
    m_ext[i]  = '0;
    m_lo[i]   = '0;
    m_up[i]   = '1;
  endtask

  task automatic model_step(input int i);
    logic r0, r1, v0, v1, er, g0, g1;
    logic [DW-1:0] dat;
    logic [MEM_ADDR:0] a_addr, a_lo, a_up;
    logic [MEM_EXTRA-1:0] a_ext;
    string nm;
    int sl, ns;
    nm = (i == 0) ? "rr" : "fp";
    r0 = (i == 0) ? bus0.req0_ready : bus1.req0_ready;
    r1 = (i == 0) ? bus0.req1_ready : bus1.req1_ready;
    v0 = (i == 0) ? bus0.resp0_valid : bus1.resp0_valid;
    v1 = (i == 0) ? bus0.resp1_valid : bus1.resp1_valid;
    dat = (i == 0) ? bus0.resp_data : bus1.resp_data;
    er  = (i == 0) ? bus0.resp_error : bus1.resp_error;
    a_addr = (i == 0) ? bus0.mem_addr : bus1.mem_addr;
    a_ext  = (i == 0) ? bus0.mem_extra : bus1.mem_extra;
    a_lo   = (i == 0) ? bus0.mem_lower : bus1.mem_lower;
    a_up   = (i == 0) ? bus0.mem_upper : bus1.mem_upper;

    if (!reset) model_reset(i);
    sl = cyc % NS;
    check_eq($sformatf("%s c%0d resp_valid{0,1}", nm, cyc), CW'({v0, v1}),
             CW'({s_vld[i][sl] & ~s_id[i][sl], s_vld[i][sl] & s_id[i][sl]}));
    if (s_vld[i][sl])
      check_eq($sformatf("%s c%0d resp{err,data}", nm, cyc), {er, dat},
               rom_read(s_addr[i][sl], s_ext[i][sl], s_lo[i][sl], s_up[i][sl]));
    s_vld[i][sl] = 1'b0;
    check_eq($sformatf("%s c%0d mem{addr,extra,lower,upper}", nm, cyc),
             CW'({a_addr, a_ext, a_lo, a_up}), CW'({m_addr[i], m_ext[i], m_lo[i], m_up[i]}));

    g0 = 1'b0;
    g1 = 1'b0;
    if (reset) begin
      if (d_req0_flush)
        for (int k = 0; k < NS; k++) if (!s_id[i][k]) s_vld[i][k] = 1'b0;
      if (d_req0_valid && d_req1_valid) begin
        if (i == 1 || m_last[i]) g0 = 1'b1;
        else g1 = 1'b1;
      end else begin
        g0 = d_req0_valid;
        g1 = d_req1_valid;
      end
    end
    check_eq($sformatf("%s c%0d ready{0,1}", nm, cyc), CW'({r0, r1}), CW'({g0, g1}));
    if (g0 || g1) begin
      ns = (cyc + LAT) % NS;
      m_last[i] = g1;
      m_addr[i] = g1 ? d_req1_addr : d_req0_addr;
      m_ext[i]  = g1 ? d_req1_extra : d_req0_extra;
      m_lo[i]   = g1 ? d_req1_lower : '0;
      m_up[i]   = g1 ? d_req1_upper : '1;
      s_vld[i][ns]  = 1'b1;
      s_id[i][ns]   = g1;
      s_addr[i][ns] = m_addr[i];
      s_ext[i][ns]  = m_ext[i];
      s_lo[i][ns]   = m_lo[i];
      s_up[i][ns]   = m_up[i];
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_step(0);
    model_step(1);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    d_req0_valid = 1'b0;
    d_req1_valid = 1'b0;
    d_req0_flush = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    for (int k = 0; k < NS; k++) begin
      s_vld[0][k] = 1'b0;
      s_vld[1][k] = 1'b0;
    end
    idle(2);
    reset = 1'b1;
    idle(10);

    // Single requester-0 read.
    d_req0_valid = 1'b1; d_req0_addr = 5'd3; d_req0_extra = 4'd7;
    step();
    idle(4);

    // Both requesters contending.
    for (int n = 0; n < 8; n++) begin
      d_req0_valid = 1'b1; d_req0_addr = 5'($urandom_range(0, 31));
      d_req1_valid = 1'b1; d_req1_addr = 5'($urandom_range(0, 31));
      d_req0_extra = 4'($urandom_range(0, 15)); d_req1_extra = 4'($urandom_range(0, 15));
      d_req1_lower = 5'd0; d_req1_upper = 5'd31;
      step();
    end
    idle(4);

    // Bounded requester-1 read, then the same window from requester 0.
    d_req1_valid = 1'b1; d_req1_addr = 5'd12; d_req1_extra = 4'd7;
    d_req1_lower = 5'd0; d_req1_upper = 5'd15;
    step();
    d_req1_valid = 1'b0;
    d_req0_valid = 1'b1; d_req0_addr = 5'd12; d_req0_extra = 4'd7;
    step();
    idle(4);

    // Flush of requester 0 in flight while requester 1 is accepted.
    d_req0_valid = 1'b1; d_req0_addr = 5'd5;
    step();
    d_req0_valid = 1'b0; d_req1_valid = 1'b1; d_req1_addr = 5'd9; d_req0_flush = 1'b1;
    step();
    idle(4);

    // Reset arriving one cycle after an accept.
    d_req0_valid = 1'b1; d_req0_addr = 5'd7;
    step();
    d_req0_valid = 1'b0; d_req1_valid = 1'b1; reset = 1'b0;
    step();
    reset = 1'b1;
    idle(5);

    for (int n = 0; n < 600; n++) begin
      d_req0_valid = 1'($urandom_range(0, 1));
      d_req1_valid = 1'($urandom_range(0, 1));
      d_req0_addr  = 5'($urandom_range(0, 31));
      d_req1_addr  = 5'($urandom_range(0, 31));
      d_req0_extra = 4'($urandom_range(0, 15));
      d_req1_extra = 4'($urandom_range(0, 15));
      d_req1_lower = 5'($urandom_range(0, 16));
      d_req1_upper = 5'($urandom_range(8, 31));
      d_req0_flush = ($urandom_range(0, 7) == 0);
      reset        = ($urandom_range(0, 99) != 0);
      step();
    end
    reset = 1'b1;
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule : tb_rom_port_arbiter
`default_nettype wire

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single genrom read port (addr/extra in, data/error out) between two requesters.
- Requester 0 is the cpu instruction/immediate fetch path. Requester 1 is a secondary reader, e.g. the module loader or debug dump.
- Issues at most one read per cycle and tracks in-flight reads with a tag pipeline. Each response is routed back to the requester that issued it.
- Sits between cpu mem_* ports and genrom. It also drives genrom lower_bound/upper_bound per granted requester.

Parameters:
- MEM_ADDR, 4, address width minus one; addresses are [MEM_ADDR:0].
- MEM_EXTRA, 4, extra-byte field width; data is 2**MEM_EXTRA*8 bits.
- LAT, 2, cycles from accept edge to response valid; legal range 1..4.
- FIXED_PRIO, 0, 0 = round-robin, 1 = requester 0 always wins.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 read request.
- req0_addr  in  MEM_ADDR+1  requester 0 byte address.
- req0_extra  in  MEM_EXTRA  requester 0 extra-byte count.
- req0_ready  out  1  requester 0 accepted this cycle (combinational).
- req0_flush  in  1  discard requester 0 in-flight responses.
- req1_valid, req1_addr, req1_extra, req1_ready  as requester 0.
- req1_lower, req1_upper  in  MEM_ADDR+1 each  bounds applied to requester 1 reads.
- resp0_valid, resp1_valid  out  1  response strobe, one cycle.
- resp_data  out  2**MEM_EXTRA*8  shared response data.
- resp_error  out  1  shared response error.
- mem_addr  out  MEM_ADDR+1  to genrom addr.
- mem_extra  out  MEM_EXTRA  to genrom extra.
- mem_lower, mem_upper  out  MEM_ADDR+1 each  to genrom bounds.
- mem_data  in  2**MEM_EXTRA*8  from genrom.
- mem_error  in  1  from genrom.

Behaviour:
- Reset (reset low, async) sets:
  - mem_addr = 0, mem_extra = 0.
  - mem_lower = 0, mem_upper = all ones.
  - Tag pipeline cleared; resp0_valid = resp1_valid = 0.
  - last_grant = 1, so requester 0 wins first.
- Reset mid-operation drops all in-flight reads silently; no response strobes afterwards.
- Arbitration (combinational, every cycle):
  - Only one valid: that requester gets ready = 1.
  - Both valid, FIXED_PRIO = 0: grant the requester not equal to last_grant.
  - Both valid, FIXED_PRIO = 1: grant requester 0.
  - Never more than one ready high per cycle.
  - No ready while reset is low.
- Accept edge (valid & ready):
  - mem_addr and mem_extra register the granted requester's addr and extra.
  - Requester 0 grant: mem_lower = 0, mem_upper = all ones.
  - Requester 1 grant: mem_lower = req1_lower, mem_upper = req1_upper.
  - last_grant updates to the granted id.
  - Idle cycles hold mem_* outputs unchanged.
- Tag pipeline:
  - LAT stages, each holding {valid, id}. The accept edge loads stage 0; the pipeline shifts every cycle.
  - Last stage valid drives resp<id>_valid high for exactly one cycle.
  - resp_data = mem_data and resp_error = mem_error, passed straight through; they are meaningful only while a resp strobe is high.
- Back-to-back accepts allowed; throughput is 1 read/cycle. Responses return in issue order.
- Flush:
  - req0_flush high at an edge clears every stage whose id = 0.
  - Requester 1 entries are untouched.
  - A request accepted at that same edge is kept: flush applies before the load.
- resp0_valid and resp1_valid are never high together.
- mem_error from genrom (out of bounds) is forwarded unchanged. The arbiter itself never raises an error.

Test Plan:
- Reset low, then high; drive no requests.
  -> mem_addr = 0, mem_upper = 5'h1F, both ready = 0, no resp strobes for 10 cycles.
- req0 only, addr 3, extra 7, ROM bytes 0..15 = index.
  -> req0_ready same cycle; resp0_valid exactly LAT = 2 cycles after accept; resp_data[7:0] = 8'h03, resp_error = 0.
- Both requesters valid continuously, FIXED_PRIO = 0.
  -> grants alternate 0,1,0,1; response ids alternate in the same order 2 cycles later.
- Same stimulus with FIXED_PRIO = 1.
  -> requester 1 never granted while req0_valid is high.
- req1 at addr 12, extra 7, req1_upper = 15.
  -> mem_upper = 15 on its accept; resp1_valid with resp_error = 1.
  -> A following req0 at addr 12 gets mem_upper = 31 and resp_error = 0.
- Accept req0 at cycle N and req1 at N+1; assert req0_flush at edge N+1.
  -> no resp0_valid; resp1_valid at N+3.
  -> Repeat with reset pulled low at N+1: no responses at all.
